// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-sequencing load/store unit: funct3 encodings,
// sequencer states and the access-width helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_LAST,
        S_RESP
    } state_t;

    // Number of single-byte memory accesses an op needs.
    function automatic logic [2:0] byte_count(input logic [2:0] funct3);
        case (funct3)
            F3_H, F3_HU: byte_count = 3'd2;
            F3_W:        byte_count = 3'd4;
            default:     byte_count = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of little-endian assembled load bytes; shared with the
// writeback mux.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] asm_data,
    output logic [31:0] result
);

    always_comb begin
        result = asm_data;
        case (funct3)
            F3_B:    result = {{24{asm_data[7]}}, asm_data[7:0]};
            F3_H:    result = {{16{asm_data[15]}}, asm_data[15:0]};
            F3_BU:   result = {24'h0, asm_data[7:0]};
            F3_HU:   result = {16'h0, asm_data[15:0]};
            default: result = asm_data;
        endcase
    end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// Splits RV32 loads/stores into single-byte accesses to a byte-only memory and
// reassembles load data into one extended response.
module lsu_byte_sequencer
    import lsu_pkg::*;
#(
    parameter bit ERR_ON_MISALIGN = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_rdata
);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_write_q, mem_write_d;
    logic        mem_read_q, mem_read_d;

    logic        write_q, write_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbytes_q, rbytes_d;

    logic [1:0]  last_idx;
    logic [31:0] asm_data;
    logic [31:0] ext_result;
    logic        req_legal;
    logic        req_misaligned;
    logic        unused_rdata;

    assign unused_rdata = ^mem_rdata[31:8];
    assign last_idx     = 2'(byte_count(f3_q) - 3'd1);

    assign req_legal = req_write ? (req_funct3 inside {F3_B, F3_H, F3_W})
                                 : (req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign req_misaligned = ERR_ON_MISALIGN &&
        ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
         (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00));

    // Memory read data is registered, so the final byte arrives during LAST.
    always_comb begin
        asm_data = rbytes_q;
        asm_data[{last_idx, 3'b000} +: 8] = mem_rdata[7:0];
    end

    lsu_load_extend u_extend (
        .funct3   (f3_q),
        .asm_data (asm_data),
        .result   (ext_result)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = 32'h0;
        mem_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        write_d      = write_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rbytes_d     = rbytes_q;
        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    write_d     = req_write;
                    f3_d        = req_funct3;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    rbytes_d    = 32'h0;
                    cnt_d       = 2'd0;
                    if (!req_legal || req_misaligned) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = S_ACCESS;
                        mem_addr_d  = req_addr;
                        mem_read_d  = !req_write;
                        mem_write_d = req_write;
                        mem_wdata_d = {24'h0, req_wdata[7:0]};
                    end
                end
            end
            S_ACCESS: begin
                if (!write_q && cnt_q != 2'd0) begin
                    rbytes_d[{cnt_q - 2'd1, 3'b000} +: 8] = mem_rdata[7:0];
                end
                if (cnt_q == last_idx) begin
                    if (write_q) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                    end else begin
                        state_d = S_LAST;
                    end
                end else begin
                    cnt_d       = cnt_q + 2'd1;
                    mem_addr_d  = addr_q + {30'h0, cnt_d};
                    mem_read_d  = !write_q;
                    mem_write_d = write_q;
                    if (write_q) begin
                        mem_wdata_d = {24'h0, wdata_q[{cnt_d, 3'b000} +: 8]};
                    end
                end
            end
            S_LAST: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = ext_result;
            end
            S_RESP: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
                resp_err_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
        end
    end

    // Request fields and partial load bytes are only consumed after an accept.
    always_ff @(posedge clk) begin
        write_q  <= write_d;
        f3_q     <= f3_d;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
        rbytes_q <= rbytes_d;
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_write  = mem_write_q;
    assign mem_read   = mem_read_q;
    assign mem_funct3 = F3_B;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Directed bench for lsu_byte_sequencer with a registered-read byte memory model.
module tb_lsu_byte_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, resp_valid, resp_err, mem_write, mem_read;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata = 32'h0;

    logic        e_req_valid = 1'b0;
    logic        e_req_ready, e_resp_valid, e_resp_err, e_mem_write, e_mem_read;
    logic [31:0] e_resp_rdata, e_mem_addr, e_mem_wdata;
    logic [2:0]  e_mem_funct3;
    logic [31:0] e_mem_rdata = 32'h0;

    logic [7:0]  mem [0:255] = '{default: 8'h00};

    int n_cmp = 0;
    int n_fail = 0;

    logic        tr_rd [1:10], tr_wr [1:10], tr_rv [1:10], tr_re [1:10], tr_rdy [1:10];
    logic [31:0] tr_addr [1:10], tr_wd [1:10], tr_rdata [1:10];

    always #5 clk = ~clk;

    lsu_byte_sequencer #(.ERR_ON_MISALIGN(1'b0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
    );

    lsu_byte_sequencer #(.ERR_ON_MISALIGN(1'b1)) dut_err (
        .clk(clk), .reset(reset),
        .req_valid(e_req_valid), .req_ready(e_req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(e_resp_valid), .resp_err(e_resp_err), .resp_rdata(e_resp_rdata),
        .mem_addr(e_mem_addr), .mem_wdata(e_mem_wdata), .mem_write(e_mem_write),
        .mem_read(e_mem_read), .mem_funct3(e_mem_funct3), .mem_rdata(e_mem_rdata)
    );

    // Byte memory: write on the edge, read data registered one cycle late.
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:0]] <= mem_wdata[7:0];
        if (mem_read) mem_rdata <= {24'hA5A5A5, mem[mem_addr[7:0]]};
    end

    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL accept_ready got %b want 1", req_ready);
        end
        req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_addr = 32'hFFFF_FFF0; req_wdata = 32'h0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            tr_rd[c] = mem_read; tr_wr[c] = mem_write; tr_rv[c] = resp_valid;
            tr_re[c] = resp_err; tr_rdy[c] = req_ready; tr_addr[c] = mem_addr;
            tr_wd[c] = mem_wdata; tr_rdata[c] = resp_rdata;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b0 ||
            resp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got rdy=%b rv=%b re=%b rd=%b wr=%b rdata=%h addr=%h wd=%h want all 0",
                     req_ready, resp_valid, resp_err, mem_read, mem_write, resp_rdata, mem_addr, mem_wdata);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_release_ready got %b want 0", req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || mem_funct3 !== 3'b000) begin
            n_fail++; $display("FAIL ready_after_reset got rdy=%b f3=%b want 1/000", req_ready, mem_funct3);
        end
    endtask

    task automatic test_store_word();
        logic [7:0] exp_b [0:3];
        exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
        do_req(1'b1, 3'b010, 32'd8, 32'hDEADBEEF);
        for (int c = 1; c <= 4; c++) begin
            n_cmp++;
            if (tr_wr[c] !== 1'b1 || tr_rd[c] !== 1'b0 || tr_rv[c] !== 1'b0 ||
                tr_addr[c] !== 32'(8 + c - 1) || tr_wd[c] !== {24'h0, exp_b[c-1]}) begin
                n_fail++;
                $display("FAIL sw_cycle%0d got wr=%b rd=%b rv=%b addr=%h wd=%h want 1/0/0 addr=%0d wd=%h",
                         c, tr_wr[c], tr_rd[c], tr_rv[c], tr_addr[c], tr_wd[c], 8 + c - 1, exp_b[c-1]);
            end
        end
        n_cmp++;
        if (tr_rv[5] !== 1'b1 || tr_re[5] !== 1'b0 || tr_wr[5] !== 1'b0 || tr_rv[6] !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_resp got rv5=%b re5=%b wr5=%b rv6=%b want 1/0/0/0", tr_rv[5], tr_re[5], tr_wr[5], tr_rv[6]);
        end
        n_cmp++;
        if (tr_rdy[5] !== 1'b0 || tr_rdy[6] !== 1'b1) begin
            n_fail++; $display("FAIL sw_ready_after_resp got %b%b want 01", tr_rdy[5], tr_rdy[6]);
        end
        n_cmp++;
        if ({mem[11], mem[10], mem[9], mem[8]} !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL sw_memory got %h want deadbeef", {mem[11], mem[10], mem[9], mem[8]});
        end
    endtask

    task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input int n, input logic [31:0] exp_data);
        do_req(1'b0, f3, a, 32'h0);
        for (int c = 1; c <= n; c++) begin
            n_cmp++;
            if (tr_rd[c] !== 1'b1 || tr_wr[c] !== 1'b0 || tr_addr[c] !== a + 32'(c - 1)) begin
                n_fail++;
                $display("FAIL %s_cycle%0d got rd=%b wr=%b addr=%h want 1/0 addr=%h",
                         name, c, tr_rd[c], tr_wr[c], tr_addr[c], a + 32'(c - 1));
            end
        end
        n_cmp++;
        if (tr_rd[n+1] !== 1'b0 || tr_rv[n+1] !== 1'b0 || tr_rv[n+2] !== 1'b1 ||
            tr_re[n+2] !== 1'b0 || tr_rdata[n+2] !== exp_data) begin
            n_fail++;
            $display("FAIL %s_resp got rd%0d=%b rv%0d=%b rv%0d=%b err=%b rdata=%h want 0/0/1/0 rdata=%h",
                     name, n+1, tr_rd[n+1], n+1, tr_rv[n+1], n+2, tr_rv[n+2], tr_re[n+2], tr_rdata[n+2], exp_data);
        end
    endtask

    task automatic test_misalign_err();
        n_cmp++;
        if (e_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL mis_ready got %b want 1", e_req_ready);
        end
        req_write = 1'b0; req_funct3 = 3'b001; req_addr = 32'd11; e_req_valid = 1'b1;
        @(posedge clk);
        #1 e_req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (e_mem_read !== 1'b0 || e_mem_write !== 1'b0 ||
                e_resp_valid !== (c == 1) || e_resp_err !== (c == 1) || e_resp_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL mis_cycle%0d got rd=%b wr=%b rv=%b err=%b rdata=%h want 0/0/%0d/%0d/0",
                         c, e_mem_read, e_mem_write, e_resp_valid, e_resp_err, e_resp_rdata, c == 1, c == 1);
            end
        end
    endtask

    task automatic test_illegal_store();
        do_req(1'b1, 3'b100, 32'd8, 32'h11223344);
        n_cmp++;
        if (tr_rv[1] !== 1'b1 || tr_re[1] !== 1'b1 || tr_rdata[1] !== 32'h000000DE ||
            tr_rv[2] !== 1'b0 || tr_re[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL illst_resp got rv1=%b err1=%b rdata=%h rv2=%b err2=%b want 1/1/000000de/0/0",
                     tr_rv[1], tr_re[1], tr_rdata[1], tr_rv[2], tr_re[2]);
        end
        for (int c = 1; c <= 10; c++) begin
            n_cmp++;
            if (tr_wr[c] !== 1'b0 || tr_rd[c] !== 1'b0) begin
                n_fail++; $display("FAIL illst_strobe%0d got wr=%b rd=%b want 0/0", c, tr_wr[c], tr_rd[c]);
            end
        end
        n_cmp++;
        if ({mem[11], mem[10], mem[9], mem[8]} !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL illst_memory got %h want deadbeef", {mem[11], mem[10], mem[9], mem[8]});
        end
    endtask

    task automatic test_reset_mid();
        req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'd8; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_read !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_started got rd=%b want 1", mem_read);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if (mem_read !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0 || resp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_async got rd=%b rv=%b rdy=%b rdata=%h want 0/0/0/0",
                     mem_read, resp_valid, req_ready, resp_rdata);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (resp_valid !== 1'b0 || mem_read !== 1'b0) begin
                n_fail++; $display("FAIL rst_mid_hold%0d got rv=%b rd=%b want 0/0", c, resp_valid, mem_read);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_ready got rdy=%b rv=%b want 1/0", req_ready, resp_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_req(1'b1, 3'b000, 32'd20, 32'h0000005A);
        n_cmp++;
        if (tr_wr[1] !== 1'b1 || tr_addr[1] !== 32'd20 || tr_wd[1] !== 32'h5A ||
            tr_wr[2] !== 1'b0 || tr_rv[2] !== 1'b1 || tr_re[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_after_reset got wr1=%b addr=%h wd=%h wr2=%b rv2=%b err=%b want 1/14/5a/0/1/0",
                     tr_wr[1], tr_addr[1], tr_wd[1], tr_wr[2], tr_rv[2], tr_re[2]);
        end
        n_cmp++;
        if (mem[20] !== 8'h5A) begin
            n_fail++; $display("FAIL sb_memory got %h want 5a", mem[20]);
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load("lw", 3'b010, 32'd8, 4, 32'hDEADBEEF);
        test_load("lb", 3'b000, 32'd9, 1, 32'hFFFFFFBE);
        test_load("lbu", 3'b100, 32'd9, 1, 32'h000000BE);
        test_load("lhu", 3'b101, 32'd10, 2, 32'h0000DEAD);
        test_load("lh_mis", 3'b001, 32'd11, 2, 32'h000000DE);
        test_misalign_err();
        test_illegal_store();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
